// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache traffic onto one RAM port, dcache first.
// Define ARB_FAIRNESS_EN to bound icache starvation by STARVE_LIMIT.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_chk
    $error("STARVE_LIMIT must be in 1..15");
  end

  logic [1:0] state;
  logic [1:0] state_n;
  logic       dreq;
  logic       fin;
  logic       i_sel;

  assign dreq = dREN | dWEN;
  assign fin  = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);

`ifdef ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;

  assign i_sel = iREN && (starve_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (!iREN) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_n == IGRANT) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_n == DGRANT
                 && starve_cnt != 4'hf) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign i_sel = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_sel)
          state_n = IGRANT;
        else if (dreq)
          state_n = DGRANT;
        else if (iREN)
          state_n = IGRANT;
      end
      IGRANT: begin
        if (!iREN || fin)
          state_n = IDLE;
      end
      DGRANT: begin
        if (!dreq || fin)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_n;
  end

  // A requester that withdraws mid-grant never sees a completion.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (iREN && ramstate == RS_ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (dreq && ramstate == RS_ACCESS) begin
          dwait = 1'b0;
          if (!dWEN)
            dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, fairness and reset
// sequences, then random traffic against a cycle-level reference model.
module tb_memory_arbiter;

  localparam int LIMIT = 2;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
    logic [31:0] il;
    logic [31:0] dl;
  } out_t;

  typedef struct {
    logic        i;
    logic [31:0] ia;
    logic        d;
    logic        w;
    logic [31:0] da;
    logic [31:0] ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    out_t        e;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;

  int errors = 0;
  int checks = 0;
  int owner  = 0;
  int starve = 0;
  bit fair_on;

  vec_t tab[23];

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ramstate(ramstate),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore)
  );

  always #5 CLK = ~CLK;

  function automatic out_t eo(
    logic ren, logic wen, logic [31:0] addr, logic [31:0] store,
    logic iw, logic dw, logic [31:0] il, logic [31:0] dl);
    out_t o;
    o.ren = ren; o.wen = wen; o.addr = addr; o.store = store;
    o.iw = iw; o.dw = dw; o.il = il; o.dl = dl;
    return o;
  endfunction

  function automatic out_t idle_out();
    return eo(0, 0, 0, 0, 1, 1, 0, 0);
  endfunction

  function automatic vec_t v(
    logic i, logic [31:0] ia, logic d, logic w,
    logic [31:0] da, logic [31:0] ds, logic [1:0] rs,
    logic [31:0] rl, out_t e);
    vec_t r;
    r.i = i; r.ia = ia; r.d = d; r.w = w;
    r.da = da; r.ds = ds; r.rs = rs; r.rl = rl; r.e = e;
    return r;
  endfunction

  // Owner 0 = nobody, 1 = icache, 2 = dcache.
  function automatic out_t model_out();
    out_t e = idle_out();
    if (owner == 1) begin
      e.ren  = 1;
      e.addr = iaddr;
      if (iREN && ramstate == ACCESS) begin
        e.iw = 0;
        e.il = ramload;
      end
    end else if (owner == 2) begin
      e.addr  = daddr;
      e.store = dstore;
      e.wen   = dWEN;
      e.ren   = dREN && !dWEN;
      if ((dREN || dWEN) && ramstate == ACCESS) begin
        e.dw = 0;
        if (!dWEN) e.dl = ramload;
      end
    end
    return e;
  endfunction

  function automatic void model_step();
    bit dq  = dREN || dWEN;
    bit fin = (ramstate == ACCESS) || (ramstate == ERROR);
    bit pick_i = fair_on && iREN && (starve >= LIMIT);
    int nxt = owner;
    case (owner)
      0: begin
        if (pick_i) nxt = 1;
        else if (dq) nxt = 2;
        else if (iREN) nxt = 1;
      end
      1: if (!iREN || fin) nxt = 0;
      2: if (!dq || fin) nxt = 0;
      default: nxt = 0;
    endcase
    if (!iREN) starve = 0;
    else if (owner == 0 && nxt == 1) starve = 0;
    else if (owner == 0 && nxt == 2) starve = (starve < 15) ? starve + 1 : 15;
    owner = nxt;
  endfunction

  task automatic check(string name, out_t exp);
    out_t act;
    act = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_model(string name);
    @(negedge CLK);
    check(name, model_out());
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic tick_tab(string name, vec_t t);
    iREN = t.i; iaddr = t.ia; dREN = t.d; dWEN = t.w;
    daddr = t.da; dstore = t.ds; ramstate = t.rs; ramload = t.rl;
    @(negedge CLK);
    check(name, t.e);
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
`ifdef ARB_FAIRNESS_EN
    fair_on = 1'b1;
`else
    fair_on = 1'b0;
`endif
    tab[0]  = v(1, 'h40, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[1]  = v(1, 'h40, 0, 0, 0, 0, BUSY, 0,
                eo(1, 0, 'h40, 0, 1, 1, 0, 0));
    tab[2]  = v(1, 'h40, 0, 0, 0, 0, ACCESS, 'h8C220004,
                eo(1, 0, 'h40, 0, 0, 1, 'h8C220004, 0));
    tab[3]  = v(0, 'h40, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[4]  = v(1, 'h40, 1, 0, 'h100, 0, FREE, 0, idle_out());
    tab[5]  = v(1, 'h48, 1, 0, 'h100, 0, BUSY, 0,
                eo(1, 0, 'h100, 0, 1, 1, 0, 0));
    tab[6]  = v(1, 'h40, 1, 0, 'h100, 0, ACCESS, 'h12345678,
                eo(1, 0, 'h100, 0, 1, 0, 0, 'h12345678));
    tab[7]  = v(1, 'h40, 0, 0, 'h100, 0, FREE, 0, idle_out());
    tab[8]  = v(1, 'h40, 0, 0, 'h104, 0, ACCESS, 'hAAAA5555,
                eo(1, 0, 'h40, 0, 0, 1, 'hAAAA5555, 0));
    tab[9]  = v(0, 0, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[10] = v(0, 0, 1, 1, 'h200, 'hDEADBEEF, FREE, 0, idle_out());
    tab[11] = v(0, 0, 1, 1, 'h200, 'hDEADBEEF, BUSY, 0,
                eo(0, 1, 'h200, 'hDEADBEEF, 1, 1, 0, 0));
    tab[12] = v(0, 0, 1, 1, 'h200, 'hDEADBEEF, ACCESS, 'hFFFFFFFF,
                eo(0, 1, 'h200, 'hDEADBEEF, 1, 0, 0, 0));
    tab[13] = v(0, 0, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[14] = v(0, 0, 1, 0, 'h300, 0, FREE, 0, idle_out());
    tab[15] = v(0, 0, 1, 0, 'h300, 0, ERROR, 'h5A5A5A5A,
                eo(1, 0, 'h300, 0, 1, 1, 0, 0));
    tab[16] = v(0, 0, 1, 0, 'h300, 0, FREE, 0, idle_out());
    tab[17] = v(0, 0, 1, 0, 'h300, 0, ACCESS, 'h11112222,
                eo(1, 0, 'h300, 0, 1, 0, 0, 'h11112222));
    tab[18] = v(0, 0, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[19] = v(1, 'h44, 0, 0, 0, 0, FREE, 0, idle_out());
    tab[20] = v(1, 'h44, 0, 0, 0, 0, BUSY, 0,
                eo(1, 0, 'h44, 0, 1, 1, 0, 0));
    tab[21] = v(0, 'h44, 0, 0, 0, 0, ACCESS, 'h77777777,
                eo(1, 0, 'h44, 0, 1, 1, 0, 0));
    tab[22] = v(0, 0, 0, 0, 0, 0, FREE, 0, idle_out());

    nRST = 0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    #2;
    check("reset_outputs", idle_out());
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    model_step();
    #1;

    for (int k = 0; k < 23; k++)
      tick_tab($sformatf("vec%0d", k), tab[k]);

    // icache and dcache both held; grant order depends on fairness build.
    iaddr = 'h500; daddr = 'h600; dstore = 0;
    iREN = 1; dREN = 1; dWEN = 0;
    for (int k = 0; k < 6; k++) begin
      ramstate = FREE;
      tick_model("fair_idle");
      ramstate = ACCESS;
      ramload = 32'(k) + 32'h100;
      @(negedge CLK);
      exp_addr = (fair_on && (k % 3 == 2)) ? 32'h500 : 32'h600;
      checks++;
      if (ramaddr !== exp_addr) begin
        errors++;
        $display("FAIL fair_grant%0d: ramaddr %h expected %h",
                 k, ramaddr, exp_addr);
      end
      check("fair_xfer", model_out());
      @(posedge CLK);
      model_step();
      #1;
    end
    iREN = 0; dREN = 0;
    tick_model("fair_drain");

    // Reset pulse in the middle of an icache grant.
    iREN = 1; iaddr = 'h700; ramstate = BUSY;
    tick_model("rst_pre_idle");
    @(negedge CLK);
    check("rst_pre_grant", model_out());
    #2;
    nRST = 0;
    owner = 0;
    starve = 0;
    #1;
    check("rst_async", idle_out());
    @(posedge CLK);
    #1;
    check("rst_held", idle_out());
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    model_step();
    #1;
    ramstate = ACCESS; ramload = 'hCAFEF00D;
    tick_model("rst_retry");
    iREN = 0; ramstate = FREE;
    tick_model("rst_done");

    for (int k = 0; k < 400; k++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 4) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      tick_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 4, max consecutive dcache grants while icache waits (range 1..15).
REQ-002 SHALL provide ports:
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- iwait  out  1  icache stalled; low = transfer done this cycle.
- dwait  out  1  dcache stalled; low = transfer done this cycle.
- iload  out  32  read data to icache.
- dload  out  32  read data to dcache.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.

Function
REQ-003 SHALL implement registered FSM with states IDLE, IGRANT, DGRANT; RAM-side outputs decoded from registered state only.
REQ-004 SHALL select from IDLE on each edge: dcache request (dREN|dWEN) -> DGRANT; else iREN -> IGRANT; else stay IDLE.
REQ-005 SHALL in IDLE drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-006 SHALL in IGRANT drive ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-007 SHALL in DGRANT drive ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins when dREN&dWEN); else ramREN=dREN.
REQ-008 SHALL drop iwait to 0 only in a cycle with state IGRANT and ramstate=ACCESS; iload=ramload that cycle, else 0.
REQ-009 SHALL drop dwait to 0 only in a cycle with state DGRANT and ramstate=ACCESS; dload=ramload that cycle (read only), else 0.
REQ-010 SHALL hold iwait=1 and dwait=1 in all other cycles; never deassert both in one cycle.
REQ-011 SHALL return to IDLE on the edge after ramstate=ACCESS; each transfer thus costs at least 2 cycles (grant + 1 IDLE bubble).
REQ-012 SHALL on ramstate=ERROR in a grant state keep wait high and return to IDLE (request retried via re-arbitration).
REQ-013 SHALL on ramstate=FREE or BUSY hold the grant state unchanged.
REQ-014 SHALL return to IDLE on next edge if granted requester deasserts its request mid-grant; no wait pulse issued.
REQ-015 SHALL ignore address/data changes of the non-granted requester.

Reset
REQ-016 SHALL on nRST=0 immediately force state IDLE and starvation counter 0, independent of CLK.
REQ-017 SHALL during reset drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, iwait=1, dwait=1.
REQ-018 SHALL on reset mid-transfer abandon the transfer; no wait low pulse; requester re-arbitrates after release.

Configuration
REQ-019 SHALL compile a fairness counter only when ARB_FAIRNESS_EN is defined.
REQ-020 SHALL with ARB_FAIRNESS_EN: 4-bit counter increments on each DGRANT entry while iREN=1, clears on IGRANT entry or iREN=0; at count=STARVE_LIMIT with iREN=1, IDLE selects IGRANT over dcache.
REQ-021 SHALL without ARB_FAIRNESS_EN: strict dcache priority per REQ-004, no counter state.

Verification
REQ-022 icache-only: iREN=1, iaddr=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40, one-cycle iwait=0, iload=0x8C220004.
REQ-023 collision: iREN=dREN=1 in IDLE, daddr=0x100 -> DGRANT first, dwait=0 on ACCESS, then IDLE, then IGRANT.
REQ-024 write priority: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dload=0 at completion.
REQ-025 fairness (macro defined, STARVE_LIMIT=2): iREN held, dREN re-asserted each transfer -> D, D, then I granted; macro undefined -> I never granted while dREN high.
REQ-026 error/reset: ramstate=ERROR in DGRANT -> dwait stays 1, IDLE, re-grant; nRST pulsed low mid-IGRANT -> ramREN=0 same cycle, iwait=1, FSM IDLE.
